// File: rtl/imem_dump_tx_pkg.sv
// Shared definitions for the instruction-memory dump path: FSM states and word geometry.
package imem_dump_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_ADV,
    ST_FIN
  } state_t;

  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned WORD_W          = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned IDX_W           = 2;
  // Low address bits that must be cleared to word-align a byte address.
  localparam int unsigned WORD_ALIGN_MASK = BYTES_PER_WORD - 1;

endpackage

// File: rtl/imem_dump_tx_ser.sv
// Word-to-byte serialiser: buffers one 32-bit word and presents it MSB first
// on a valid/ready byte stream.
module word_to_byte_ser
  import imem_dump_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_tx_ready,
  output logic [BYTE_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  output logic              o_word_done_c
);

  logic [WORD_W-1:0] r_buf;
  logic [IDX_W-1:0]  r_idx;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_tx_valid;

  logic              w_hs;
  logic [IDX_W-1:0]  w_next_idx;
  logic [BYTE_W-1:0] w_next_byte;

  assign w_hs          = r_tx_valid && i_tx_ready;
  assign w_next_idx    = r_idx + IDX_W'(1);
  assign o_word_done_c = w_hs && (r_idx == IDX_W'(BYTES_PER_WORD - 1));

  // Byte that follows the one currently on the bus.
  always_comb begin
    w_next_byte = r_buf[31:24];
    case (w_next_idx)
      2'd1:    w_next_byte = r_buf[23:16];
      2'd2:    w_next_byte = r_buf[15:8];
      2'd3:    w_next_byte = r_buf[7:0];
      default: w_next_byte = r_buf[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= '0;
      r_idx      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else if (i_load) begin
      r_buf      <= i_word;
      r_idx      <= '0;
      r_tx_data  <= i_word[31:24];
      r_tx_valid <= 1'b1;
    end else if (w_hs) begin
      if (o_word_done_c) begin
        r_tx_valid <= 1'b0;
      end else begin
        r_idx     <= w_next_idx;
        r_tx_data <= w_next_byte;
      end
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;

endmodule

// File: rtl/imem_dump_tx.sv
// Instruction-memory dump: walks a word-aligned PC range through the memory's
// synchronous read port and streams each word out as 4 bytes, MSB first.
module imem_dump_tx
  import imem_dump_tx_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   start_pc,
  input  logic [PC_WIDTH-1:0]   end_pc,
  output logic                  mem_rd_en,
  output logic [PC_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(WORD_ALIGN_MASK));
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(BYTES_PER_WORD);

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_cur_pc;
  logic [PC_WIDTH-1:0] r_last_pc;
  logic                r_err;
  logic                r_mem_rd_en;
  logic [PC_WIDTH-1:0] r_mem_rd_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_range_err;

  logic [PC_WIDTH-1:0] w_start_al;
  logic [PC_WIDTH-1:0] w_end_al;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic                w_load;
  logic                w_word_done;

  assign w_start_al = start_pc & ALIGN_MASK;
  assign w_end_al   = end_pc & ALIGN_MASK;
  assign w_next_pc  = r_cur_pc + PC_STEP;
  assign w_load     = (r_state == ST_WAIT);

  // Control FSM and address walk; done/busy/range_err are set on entry to FIN
  // so they are visible during the FIN cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cur_pc      <= '0;
      r_last_pc     <= '0;
      r_err         <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_range_err   <= 1'b0;
    end else begin
      r_mem_rd_en <= 1'b0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cur_pc  <= w_start_al;
            r_last_pc <= w_end_al;
            if (w_start_al > w_end_al) begin
              r_err       <= 1'b1;
              r_done      <= 1'b1;
              r_range_err <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_FIN;
            end else begin
              r_err         <= 1'b0;
              r_busy        <= 1'b1;
              r_mem_rd_en   <= 1'b1;
              r_mem_rd_addr <= w_start_al;
              r_state       <= ST_READ;
            end
          end
        end
        ST_READ: r_state <= ST_WAIT;
        ST_WAIT: r_state <= ST_SEND;
        ST_SEND: begin
          if (w_word_done) r_state <= ST_ADV;
        end
        ST_ADV: begin
          // Equality stop keeps the walk from wrapping past the top of memory.
          if (r_cur_pc == r_last_pc) begin
            r_done      <= 1'b1;
            r_range_err <= r_err;
            r_busy      <= 1'b0;
            r_state     <= ST_FIN;
          end else begin
            r_cur_pc      <= w_next_pc;
            r_mem_rd_en   <= 1'b1;
            r_mem_rd_addr <= w_next_pc;
            r_state       <= ST_READ;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  word_to_byte_ser u_ser (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_word        (WORD_W'(mem_rd_data)),
    .i_tx_ready    (tx_ready),
    .o_tx_data     (tx_data),
    .o_tx_valid    (tx_valid),
    .o_word_done_c (w_word_done)
  );

  assign mem_rd_en   = r_mem_rd_en;
  assign mem_rd_addr = r_mem_rd_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign range_err   = r_range_err;

endmodule

// File: tb/tb_imem_dump_tx.sv
// Directed bench for imem_dump_tx: memory model, byte/read monitor, scenario tasks.
module tb_imem_dump_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_pc = '0;
  logic [31:0] end_pc = '0;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        range_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  q_bytes[$];
  logic [31:0] q_rd[$];
  int          n_done = 0;
  int          n_stall_viol = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = '0;
  bit          bp_en = 0;
  int          bp_ptr = 0;
  bit          bp_pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  imem_dump_tx #(.PC_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .end_pc(end_pc),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .range_err(range_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h8c09_0000;
      32'h0000_0004: return 32'h2008_0004;
      32'h0000_0008: return 32'h8d02_0000;
      32'h0000_000C: return 32'hac49_0000;
      32'h0000_0010: return 32'h0800_0000;
      32'hFFFF_FFF8: return 32'h1122_3344;
      32'hFFFF_FFFC: return 32'h5566_7788;
      default:       return 32'hEEEE_EEEE;
    endcase
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_word(mem_rd_addr);

  // Monitor: accepted bytes, read addresses, done pulses, stall stability.
  always @(posedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) q_bytes.push_back(tx_data);
      if (mem_rd_en) q_rd.push_back(mem_rd_addr);
      if (done) n_done++;
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) n_stall_viol++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 0;
    end
  end

  always @(negedge clk) begin
    if (bp_en) begin
      tx_ready = bp_pat[bp_ptr % 8];
      bp_ptr++;
    end else begin
      tx_ready = 1'b1;
    end
  end

  task automatic clear_mon();
    q_bytes.delete();
    q_rd.delete();
  endtask

  // Pulses start for one cycle; returns at the negedge after it was sampled.
  task automatic do_start(input logic [31:0] sp, input logic [31:0] ep);
    @(negedge clk);
    start = 1'b1; start_pc = sp; end_pc = ep;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd_en got %b want 0", mem_rd_en); end
    n_vec++; if (mem_rd_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_rd_addr got %h want 0", mem_rd_addr); end
    n_vec++; if (tx_data !== 8'h0) begin n_err++; $display("FAIL reset_tx_data got %h want 0", tx_data); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (range_err !== 1'b0) begin n_err++; $display("FAIL reset_range_err got %b want 0", range_err); end
    rst = 1'b0;
  endtask

  task automatic test_full_dump();
    logic [7:0] exp[20] = '{8'h8c, 8'h09, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h04,
                            8'h8d, 8'h02, 8'h00, 8'h00, 8'hac, 8'h49, 8'h00, 8'h00,
                            8'h08, 8'h00, 8'h00, 8'h00};
    bit ok;
    clear_mon();
    do_start(32'h0, 32'h10);
    n_vec++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'h0) begin n_err++; $display("FAIL full_first_read got en=%b addr=%h want en=1 addr=0", mem_rd_en, mem_rd_addr); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy got %b want 1", busy); end
    @(negedge clk);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL full_latency_early got tx_valid=%b want 0", tx_valid); end
    @(negedge clk);
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h8c) begin n_err++; $display("FAIL full_first_byte got v=%b d=%h want v=1 d=8c", tx_valid, tx_data); end
    wait_done(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL full_done_timeout got no done want done"); end
    n_vec++; if (range_err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL full_end_flags got range_err=%b busy=%b want 0 0", range_err, busy); end
    n_vec++; if (q_bytes.size() != 20) begin n_err++; $display("FAIL full_byte_count got %0d want 20", q_bytes.size()); end
    for (int i = 0; i < 20 && i < q_bytes.size(); i++) begin
      n_vec++; if (q_bytes[i] !== exp[i]) begin n_err++; $display("FAIL full_byte[%0d] got %h want %h", i, q_bytes[i], exp[i]); end
    end
    n_vec++; if (q_rd.size() != 5) begin n_err++; $display("FAIL full_read_count got %0d want 5", q_rd.size()); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[4] = '{8'h20, 8'h08, 8'h00, 8'h04};
    bit ok;
    clear_mon();
    n_stall_viol = 0;
    bp_ptr = 0;
    bp_en = 1;
    do_start(32'h4, 32'h4);
    wait_done(200, ok);
    bp_en = 0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_done_timeout got no done want done"); end
    n_vec++; if (q_bytes.size() != 4) begin n_err++; $display("FAIL bp_byte_count got %0d want 4", q_bytes.size()); end
    for (int i = 0; i < 4 && i < q_bytes.size(); i++) begin
      n_vec++; if (q_bytes[i] !== exp[i]) begin n_err++; $display("FAIL bp_byte[%0d] got %h want %h", i, q_bytes[i], exp[i]); end
    end
    n_vec++; if (n_stall_viol != 0) begin n_err++; $display("FAIL bp_stall_stable got %0d changes want 0", n_stall_viol); end
    n_vec++; if (q_rd.size() != 1 || q_rd[0] !== 32'h4) begin n_err++; $display("FAIL bp_reads got count=%0d want one read at 00000004", q_rd.size()); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    logic [7:0] exp[8] = '{8'h20, 8'h08, 8'h00, 8'h04, 8'h8d, 8'h02, 8'h00, 8'h00};
    bit ok;
    clear_mon();
    do_start(32'h6, 32'hB);
    wait_done(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mis_done_timeout got no done want done"); end
    n_vec++; if (q_bytes.size() != 8) begin n_err++; $display("FAIL mis_byte_count got %0d want 8", q_bytes.size()); end
    for (int i = 0; i < 8 && i < q_bytes.size(); i++) begin
      n_vec++; if (q_bytes[i] !== exp[i]) begin n_err++; $display("FAIL mis_byte[%0d] got %h want %h", i, q_bytes[i], exp[i]); end
    end
    n_vec++; if (q_rd.size() != 2 || q_rd[0] !== 32'h4 || q_rd[1] !== 32'h8) begin n_err++; $display("FAIL mis_reads got count=%0d want reads at 4 and 8", q_rd.size()); end
    @(negedge clk);
  endtask

  task automatic test_range_err();
    clear_mon();
    do_start(32'h10, 32'h0);
    n_vec++; if (done !== 1'b1 || range_err !== 1'b1) begin n_err++; $display("FAIL rerr_flags got done=%b range_err=%b want 1 1", done, range_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rerr_busy got %b want 0", busy); end
    repeat (4) @(negedge clk);
    n_vec++; if (done !== 1'b0 || range_err !== 1'b0) begin n_err++; $display("FAIL rerr_pulse_width got done=%b range_err=%b want 0 0", done, range_err); end
    n_vec++; if (q_bytes.size() != 0 || q_rd.size() != 0) begin n_err++; $display("FAIL rerr_activity got bytes=%0d reads=%0d want 0 0", q_bytes.size(), q_rd.size()); end
  endtask

  task automatic test_top_boundary();
    logic [7:0] exp[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bit ok;
    clear_mon();
    do_start(32'hFFFF_FFF8, 32'hFFFF_FFFF);
    wait_done(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL top_done_timeout got no done want done"); end
    n_vec++; if (q_rd.size() != 2 || q_rd[0] !== 32'hFFFF_FFF8 || q_rd[1] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL top_reads got count=%0d want reads at fffffff8 fffffffc", q_rd.size()); end
    n_vec++; if (q_bytes.size() != 8) begin n_err++; $display("FAIL top_byte_count got %0d want 8", q_bytes.size()); end
    for (int i = 0; i < 8 && i < q_bytes.size(); i++) begin
      n_vec++; if (q_bytes[i] !== exp[i]) begin n_err++; $display("FAIL top_byte[%0d] got %h want %h", i, q_bytes[i], exp[i]); end
    end
    repeat (5) @(negedge clk);
    n_vec++; if (q_rd.size() != 2) begin n_err++; $display("FAIL top_no_wrap got %0d reads want 2", q_rd.size()); end
  endtask

  task automatic test_reset_mid();
    int  done_before;
    bit  reached = 0;
    bit  ok;
    clear_mon();
    done_before = n_done;
    do_start(32'h0, 32'h10);
    for (int i = 0; i < 100; i++) begin
      if (q_bytes.size() >= 5) begin reached = 1; break; end
      @(negedge clk);
    end
    n_vec++; if (!reached || tx_valid !== 1'b1 || tx_data !== 8'h08) begin n_err++; $display("FAIL rmid_position got reached=%b v=%b d=%h want 1 1 08", reached, tx_valid, tx_data); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if ({mem_rd_en, tx_valid, busy, done, range_err} !== 5'b0 || tx_data !== 8'h0 || mem_rd_addr !== 32'h0) begin
      n_err++; $display("FAIL rmid_outputs got en=%b v=%b busy=%b done=%b rerr=%b d=%h addr=%h want all 0", mem_rd_en, tx_valid, busy, done, range_err, tx_data, mem_rd_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (n_done != done_before) begin n_err++; $display("FAIL rmid_no_done got %0d done pulses want 0", n_done - done_before); end
    clear_mon();
    do_start(32'h0, 32'h10);
    wait_done(200, ok);
    n_vec++; if (!ok || q_bytes.size() != 20) begin n_err++; $display("FAIL rmid_restart got ok=%b bytes=%0d want 1 20", ok, q_bytes.size()); end
    n_vec++; if (q_bytes.size() > 0 && q_bytes[0] !== 8'h8c) begin n_err++; $display("FAIL rmid_restart_first got %h want 8c", q_bytes[0]); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int  done_before;
    bit  ok;
    clear_mon();
    done_before = n_done;
    do_start(32'h0, 32'h10);
    repeat (8) @(negedge clk);
    start = 1'b1; start_pc = 32'h8; end_pc = 32'h8;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ign_done_timeout got no done want done"); end
    n_vec++; if (q_bytes.size() != 20) begin n_err++; $display("FAIL ign_byte_count got %0d want 20", q_bytes.size()); end
    n_vec++; if (q_rd.size() != 5 || q_rd[4] !== 32'h10) begin n_err++; $display("FAIL ign_reads got count=%0d want 5 ending at 10", q_rd.size()); end
    repeat (4) @(negedge clk);
    n_vec++; if (n_done - done_before != 1 || busy !== 1'b0) begin n_err++; $display("FAIL ign_single_done got %0d pulses busy=%b want 1 0", n_done - done_before, busy); end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_misaligned();
    test_range_err();
    test_top_boundary();
    test_reset_mid();
    test_ignored_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_dump_tx.md
Name: imem_dump_tx

Overview:
Reader-side counterpart of the instruction-memory load path (pc, instruction, no-op stream). On command, it walks a word-aligned PC range of instruction memory through the memory's synchronous read port. Each 32-bit instruction is serialised as 4 bytes, MSB first, onto a valid/ready byte stream that feeds the existing UART transmitter. It sits beside the instruction memory in the debug core and is used to verify loaded programs over uart_tx.

Parameters:
PC_WIDTH, 32, width of PC / memory byte address
DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle command pulse; sampled only in IDLE
start_pc  input  PC_WIDTH  first byte address of dump, inclusive; bits [1:0] ignored
end_pc  input  PC_WIDTH  last byte address of dump, inclusive; bits [1:0] ignored
mem_rd_en  output  1  instruction-memory read strobe
mem_rd_addr  output  PC_WIDTH  read byte address, bits [1:0] always 0
mem_rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte when tx_valid && tx_ready
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of dump
range_err  output  1  one-cycle pulse with done when the aligned start_pc > aligned end_pc

Behaviour:
- Reset values: mem_rd_en=0, mem_rd_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, range_err=0. State is IDLE. Internal cur_pc, last_pc, word buffer and byte index are all cleared.
- The FSM has six states: IDLE, READ, WAIT, SEND, ADV, FIN.
- IDLE:
  - On start, latch cur_pc={start_pc[PC_WIDTH-1:2],2'b00} and last_pc={end_pc[PC_WIDTH-1:2],2'b00}, and set busy=1.
  - If cur_pc > last_pc, go to FIN with the error flag set.
  - Otherwise go to READ.
- READ: drive mem_rd_en=1 and mem_rd_addr=cur_pc for exactly one cycle, then go to WAIT.
- WAIT: capture mem_rd_data into the word buffer, set byte index to 0, then go to SEND.
- SEND:
  - tx_valid=1 and tx_data=buffer[31-8*idx -: 8], so byte 0 is bits [31:24].
  - On a handshake with idx==3, go to ADV. On a handshake with idx<3, increment idx.
  - tx_data and tx_valid hold stable while tx_ready=0. tx_valid never drops without a handshake.
- ADV:
  - If cur_pc==last_pc, go to FIN.
  - Otherwise cur_pc+=4 and go to READ.
  - The equality compare prevents wrap-around: last_pc=0xFFFFFFFC ends after that word and never reads 0x00000000.
- FIN:
  - done=1 for one cycle. range_err=1 in the same cycle if the error flag is set.
  - busy drops to 0 in the same cycle. Return to IDLE.
- Latency from start to the first tx_valid is 3 cycles (IDLE→READ→WAIT→SEND). Each word costs 4 handshakes plus 3 overhead cycles (ADV, READ, WAIT).
- start while busy is ignored, with no effect on the latched range.
- start_pc==end_pc dumps exactly one word (4 bytes).
- Reset mid-operation aborts immediately. All outputs return to reset values next cycle. No partial-word completion; no done pulse.
- tx_ready high outside SEND has no effect.
- Unsigned compare and unsigned add. cur_pc is PC_WIDTH bits.

Decomposition:
- Shared debug package holds:
  - the state enum (IDLE, READ, WAIT, SEND, ADV, FIN)
  - BYTES_PER_WORD=4
  - WORD_ALIGN_MASK
- One natural sub-module, word_to_byte_ser: holds the 32-bit buffer and 2-bit index and drives the MSB-first byte output with the valid/ready handshake. The top holds the FSM and the address walk.

Test Plan:
1. Full program dump. Memory holds 0x8c090000, 0x20080004, 0x8d020000, 0xac490000, 0x08000000 at 0x0–0x10. start_pc=0, end_pc=0x10, tx_ready=1. Required: 20 bytes 8c 09 00 00 20 08 00 04 8d 02 00 00 ac 49 00 00 08 00 00 00, then done=1, range_err=0, busy=0.
2. Backpressure, single word. Same memory, start_pc=end_pc=0x4, tx_ready toggled 1-0-0-1 pseudo-randomly. Required: exactly 4 bytes 20 08 00 04 with tx_data stable while stalled. mem_rd_en pulses once with address 0x4.
3. Misaligned range and range error.
   - start_pc=0x6, end_pc=0xB: required dump of words 0x4 and 0x8 (8 bytes).
   - start_pc=0x10, end_pc=0x0: required done and range_err together 1 cycle after start, no tx_valid, no mem_rd_en.
4. Top-of-address boundary. start_pc=0xFFFFFFF8, end_pc=0xFFFFFFFF. Required: reads at 0xFFFFFFF8 and 0xFFFFFFFC only, then done, with no read at 0x0.
5. Reset and ignored start.
   - Assert rst during the 2nd byte of word 2 in scenario 1: required all outputs 0 next cycle, no done. A fresh start afterwards dumps from the beginning correctly.
   - A second start pulse mid-dump: required to be ignored, byte count unchanged.
